stopwatch_bcd: RTL and testbench

Four-digit BCD stopwatch core that produces the nibbles feeding the per-digit seven-segment decoders on the DE0 display path. It debounces two active-low push buttons, start/stop and clear, and runs a prescaled tick. On each tick it advances a 0000–9999 decimal count. Each 4-bit slice of `digits` drives one decoder instance directly; values are always 0–9, so decoder codes A–F are never produced.

---
 rtl/stopwatch_bcd.sv | 121 ++++++++++++
 tb/tb_stopwatch_bcd.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// Four-digit BCD stopwatch: debounced start/stop and clear buttons, prescaled step,
// 0000-9999 count with a one-cycle wrap pulse on rollover.
module stopwatch_bcd #(
    parameter int unsigned DIV       = 5_000_000,
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start_n,
    input  logic        btn_clear_n,
    output logic [15:0] digits,
    output logic        running,
    output logic        wrap
);

    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned DW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

    typedef enum logic {
        STOP,
        RUN
    } state_e;

    // Button vectors: bit 0 = start/stop, bit 1 = clear.
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          deb_q, deb_d;
    logic [1:0]          press_q, press_d;
    logic [DW-1:0]       dbc_q [2];
    logic [DW-1:0]       dbc_d [2];
    logic [PW-1:0]       presc_q, presc_d;
    logic [3:0][3:0]     digits_q, digits_d;
    logic                wrap_q, wrap_d;
    logic                carry;
    state_e              state_q, state_d;

    always_comb begin
        sync1_d = {btn_clear_n, btn_start_n};
        sync2_d = sync1_q;
        for (int unsigned i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            dbc_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dbc_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + 1'b1;
                end
            end
        end
        // Press events are the registered falling edge of the debounced level.
        press_d = deb_q & ~deb_d;
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        digits_d = digits_q;
        wrap_d   = 1'b0;
        carry    = 1'b0;
        if (press_q[0]) begin
            state_d = (state_q == RUN) ? STOP : RUN;
        end
        // Clear outranks a coincident step: no increment and no wrap.
        if (press_q[1]) begin
            presc_d  = '0;
            digits_d = '0;
        end else if (state_q == RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                carry   = 1'b1;
                for (int unsigned i = 0; i < 4; i++) begin
                    if (carry) begin
                        if (digits_q[i] >= 4'd9) begin
                            digits_d[i] = 4'd0;
                        end else begin
                            digits_d[i] = digits_q[i] + 4'd1;
                            carry       = 1'b0;
                        end
                    end
                end
                wrap_d = carry;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            deb_q    <= '1;
            press_q  <= '0;
            dbc_q[0] <= '0;
            dbc_q[1] <= '0;
            presc_q  <= '0;
            digits_q <= '0;
            wrap_q   <= 1'b0;
            state_q  <= STOP;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            deb_q    <= deb_d;
            press_q  <= press_d;
            dbc_q[0] <= dbc_d[0];
            dbc_q[1] <= dbc_d[1];
            presc_q  <= presc_d;
            digits_q <= digits_d;
            wrap_q   <= wrap_d;
            state_q  <= state_d;
        end
    end

    assign digits  = digits_q;
    assign running = (state_q == RUN);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: directed scenarios plus random button traffic, all
// outputs compared every cycle against a sample-window/integer-count model.
module tb_stopwatch_bcd;

    localparam int unsigned DIV = 4;
    localparam int unsigned DB  = 3;
    localparam int unsigned HL  = DB + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_start_n;
    logic        btn_clear_n;
    logic [15:0] digits;
    logic        running;
    logic        wrap;

    always #5 clk = ~clk;

    stopwatch_bcd #(.DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_start_n(btn_start_n),
        .btn_clear_n(btn_clear_n),
        .digits     (digits),
        .running    (running),
        .wrap       (wrap)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;

    // Model: decimal count as an integer, debounce as "last DB synced samples
    // all disagree with the current level"; raw samples reach the debouncer 2 edges late.
    int unsigned m_cnt, m_presc;
    bit          m_run, m_wrap, deb_s, deb_c, pend_s, pend_c;
    bit          hist_s [HL];
    bit          hist_c [HL];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [15:0] to_bcd(input int unsigned n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_presc = 0; m_run = 0; m_wrap = 0;
        deb_s = 1; deb_c = 1; pend_s = 0; pend_c = 0;
        for (int j = 0; j < HL; j++) begin
            hist_s[j] = 1; hist_c[j] = 1;
        end
    endtask

    task automatic model_step(input bit s, input bit c);
        bit flip_s, flip_c;
        m_wrap = 0;
        if (pend_c) begin
            m_cnt = 0; m_presc = 0;
        end else if (m_run) begin
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_cnt   = (m_cnt + 1) % 10000;
                m_wrap  = (m_cnt == 0);
            end else begin
                m_presc++;
            end
        end
        if (pend_s) m_run = !m_run;
        for (int j = HL - 1; j > 0; j--) begin
            hist_s[j] = hist_s[j-1]; hist_c[j] = hist_c[j-1];
        end
        hist_s[0] = s; hist_c[0] = c;
        flip_s = 1; flip_c = 1;
        for (int j = 2; j < HL; j++) begin
            if (hist_s[j] == deb_s) flip_s = 0;
            if (hist_c[j] == deb_c) flip_c = 0;
        end
        pend_s = flip_s && deb_s;
        pend_c = flip_c && deb_c;
        if (flip_s) deb_s = !deb_s;
        if (flip_c) deb_c = !deb_c;
    endtask

    task automatic cycle(input bit s, input bit c);
        btn_start_n = s;
        btn_clear_n = c;
        @(posedge clk);
        if (rst_n) model_step(s, c);
        cyc++;
        @(negedge clk);
        check("digits",  32'(digits),  32'(to_bcd(m_cnt)));
        check("running", 32'(running), 32'(m_run));
        check("wrap",    32'(wrap),    32'(m_wrap));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digits"},  32'(digits),  32'h0);
        check({tag, "_running"}, 32'(running), 32'h0);
        check({tag, "_wrap"},    32'(wrap),    32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned rise, toggles, frozen, seg;
        bit          prev, seen, run_before, s, c;

        rst_n = 1'b0; btn_start_n = 1'b1; btn_clear_n = 1'b1;
        model_reset();

        for (int i = 0; i < 8; i++) begin
            btn_start_n = 1'($urandom_range(0, 1));
            btn_clear_n = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_zero("reset");
        end
        btn_start_n = 1'b1; btn_clear_n = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) cycle(1, 1);
        check_zero("idle");

        // Start: hold 10 cycles, running rises on the 6th edge, then steps every 4.
        rise = 0;
        for (int i = 1; i <= 50; i++) begin
            cycle(i <= 10 ? 1'b0 : 1'b1, 1);
            if (running && rise == 0) rise = i;
            if (rise != 0 && i == rise + 4)  check("step1",  32'(digits), 32'h0001);
            if (rise != 0 && i == rise + 8)  check("step2",  32'(digits), 32'h0002);
            if (rise != 0 && i == rise + 40) check("step10", 32'(digits), 32'h0010);
        end
        check("start_latency", rise, 6);

        // Bounce: 2-cycle runs never reach DB; then a clean hold toggles once.
        toggles = 0; prev = running;
        for (int i = 0; i < 20; i++) begin
            cycle((i / 2) % 2 == 1, 1);
            if (running != prev) toggles++;
            prev = running;
        end
        check("bounce_toggles", toggles, 0);
        toggles = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(i >= 5, 1);
            if (running != prev) toggles++;
            prev = running;
        end
        check("hold_toggles", toggles, 1);
        check("hold_stopped", 32'(running), 32'h0);

        // Pause with prescaler at 2, then resume: next step 2 cycles after running.
        for (int i = 0; i < 12; i++) cycle(i >= 5, 1);
        for (int k = 0; k < 8 && m_presc != 0; k++) cycle(1, 1);
        for (int i = 0; i < 12; i++) cycle(i >= 5, 1);
        check("paused", 32'(running), 32'h0);
        frozen = m_cnt;
        for (int i = 0; i < 100; i++) cycle(1, 1);
        check("frozen", 32'(digits), 32'(to_bcd(frozen)));
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(i > 5, 1);
            if (running && rise == 0) rise = i;
            if (rise != 0 && i == rise + 1) check("resume_hold", 32'(digits), 32'(to_bcd(frozen)));
            if (rise != 0 && i == rise + 2) check("resume_step", 32'(digits), 32'(to_bcd((frozen + 1) % 10000)));
        end
        check("resume_rise", rise, 6);

        // Wrap from 9999 to 0000.
        seen = 0;
        for (int k = 0; k < 45000 && !seen; k++) begin
            cycle(1, 1);
            if (wrap) begin
                seen = 1;
                check("wrap_digits",  32'(digits),  32'h0);
                check("wrap_running", 32'(running), 32'h1);
            end
        end
        check("wrap_seen", 32'(seen), 32'h1);
        cycle(1, 1);
        check("wrap_one_cycle", 32'(wrap), 32'h0);

        // Clear press lands on the step edge out of 0009.
        for (int k = 0; k < 100 && !(m_cnt == 8 && m_presc == 2); k++) cycle(1, 1);
        for (int i = 1; i <= 12; i++) begin
            cycle(1, i > 5);
            if (i == 5) check("clr_pre", 32'(digits), 32'h0009);
            if (i == 6) begin
                check("clr_digits", 32'(digits), 32'h0);
                check("clr_wrap",   32'(wrap),   32'h0);
            end
        end

        // Start and clear in the same cycle.
        for (int i = 0; i < 20; i++) cycle(1, 1);
        run_before = running;
        for (int i = 1; i <= 12; i++) begin
            cycle(i > 5, i > 5);
            if (i == 6) begin
                check("both_digits",  32'(digits),  32'h0);
                check("both_running", 32'(running), 32'(!run_before));
            end
        end

        // Random button traffic with one asynchronous reset mid-count.
        for (int n = 0; n < 400; n++) begin
            seg = $urandom_range(1, 8);
            s = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < int'(seg); i++) cycle(s, c);
            if (n == 200) begin
                #2 rst_n = 1'b0;
                #1 check_zero("async_reset");
                model_reset();
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                btn_start_n = 1'b1; btn_clear_n = 1'b1;
                rst_n = 1'b1;
                for (int i = 0; i < 10; i++) cycle(1, 1);
                check_zero("post_reset");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
